// File: rtl/reaction_pkg.sv
// Shared types and defaults for the reaction-time game round sequencer.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_LIGHT,
    TIMING,
    DONE,
    FAULT
  } state_t;

  localparam int                      RT_W_DEFAULT      = 10;
  localparam logic [RT_W_DEFAULT-1:0] RT_SAT            = '1;
  localparam logic [7:0]              MIN_DELAY_DEFAULT = 8'd16;
  localparam int                      TIMEOUT_MS_DEFAULT = 999;

  // Very short random delays make the light trivially predictable, so clamp from below.
  function automatic logic [7:0] clamp_delay(input logic [7:0] value, input logic [7:0] floor_val);
    return (value < floor_val) ? floor_val : value;
  endfunction

endpackage

// File: rtl/reaction_ctrl_rise_edge.sv
// Registered rising-edge detector; reset preloads the history with the live level.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;

  // History tracks the input even in reset, so a button held through reset gives no edge.
  always_ff @(posedge clk) begin
    prev <= din;
    if (rst) rise <= 1'b0;
    else     rise <= din & ~prev;
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Round sequencer for the reaction-time game: arms the lighter, times the press, reports result.
// Optional best-time tracking is enabled with macro REACTION_BEST_TIME_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | no round yet since reset; lighter off
// ARM        | one cycle: delay_num stable before lighter is enabled
// WAIT_LIGHT | lighter counting its delay; a press here is a false start
// TIMING     | LED lit; counting ms ticks until press or timeout
// DONE       | round ended with a valid time or a timeout
// FAULT      | round ended with a false start
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int         RT_W       = RT_W_DEFAULT,
  parameter logic [7:0] MIN_DELAY  = MIN_DELAY_DEFAULT,
  parameter int         TIMEOUT_MS = TIMEOUT_MS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_btn,
  input  logic            react_btn,
  input  logic [7:0]      rand_num,
  input  logic            tick_ms,
  input  logic            lighter_done,
  output logic            lighter_en,
  output logic [7:0]      delay_num,
  output logic [RT_W-1:0] react_time,
  output logic            result_valid,
  output logic            false_start,
  output logic            timeout,
  output logic            busy,
  output logic [RT_W-1:0] best_time
);

  localparam logic [RT_W-1:0] CNT_LAST = RT_W'(TIMEOUT_MS - 1);

  logic start_rise;
  logic react_rise;

  rise_edge u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (start_btn),
    .rise (start_rise)
  );

  rise_edge u_react_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (react_btn),
    .rise (react_rise)
  );

  state_t          state_q, state_d;
  logic [RT_W-1:0] cnt_q, cnt_d;
  logic [7:0]      delay_q, delay_d;
  logic [RT_W-1:0] react_q, react_d;
  logic            en_q, en_d;
  logic            rv_q, rv_d;
  logic            fs_q, fs_d;
  logic            to_q, to_d;
  logic            busy_q, busy_d;
  logic            valid_hit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    delay_d   = delay_q;
    react_d   = react_q;
    rv_d      = 1'b0;
    fs_d      = fs_q;
    to_d      = to_q;
    valid_hit = 1'b0;

    case (state_q)
      IDLE, DONE, FAULT: begin
        if (start_rise) begin
          delay_d = clamp_delay(rand_num, MIN_DELAY);
          fs_d    = 1'b0;
          to_d    = 1'b0;
          state_d = ARM;
        end
      end
      ARM: state_d = WAIT_LIGHT;
      WAIT_LIGHT: begin
        // A press in the same cycle the light comes on still counts as early.
        if (react_rise) begin
          fs_d    = 1'b1;
          react_d = '0;
          rv_d    = 1'b1;
          state_d = FAULT;
        end else if (lighter_done) begin
          cnt_d   = '0;
          state_d = TIMING;
        end
      end
      TIMING: begin
        if (react_rise) begin
          react_d   = cnt_q;
          rv_d      = 1'b1;
          valid_hit = 1'b1;
          state_d   = DONE;
        end else if (tick_ms) begin
          cnt_d = cnt_q + RT_W'(1);
          if (cnt_q == CNT_LAST) begin
            to_d    = 1'b1;
            react_d = '1;
            rv_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    en_d   = (state_d == WAIT_LIGHT) || (state_d == TIMING);
    busy_d = en_d || (state_d == ARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      react_q <= '0;
      en_q    <= 1'b0;
      rv_q    <= 1'b0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      react_q <= react_d;
      en_q    <= en_d;
      rv_q    <= rv_d;
      fs_q    <= fs_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

`ifdef REACTION_BEST_TIME_EN
  logic [RT_W-1:0] best_q;

  always_ff @(posedge clk) begin
    if (rst)                              best_q <= '1;
    else if (valid_hit && cnt_q < best_q) best_q <= cnt_q;
  end

  assign best_time = best_q;
`else
  assign best_time = '1;
`endif

  assign lighter_en   = en_q;
  assign delay_num    = delay_q;
  assign react_time   = react_q;
  assign result_valid = rv_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed self-checking bench for reaction_ctrl; best-time expectations follow REACTION_BEST_TIME_EN.
module tb_reaction_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       react_btn = 1'b0;
  logic [7:0] rand_num = 8'd0;
  logic       tick_ms = 1'b0;
  logic       lighter_done = 1'b0;
  logic       lighter_en;
  logic [7:0] delay_num;
  logic [9:0] react_time;
  logic       result_valid;
  logic       false_start;
  logic       timeout;
  logic       busy;
  logic [9:0] best_time;

  int tests = 0;
  int fails = 0;

`ifdef REACTION_BEST_TIME_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  reaction_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_btn    (start_btn),
    .react_btn    (react_btn),
    .rand_num     (rand_num),
    .tick_ms      (tick_ms),
    .lighter_done (lighter_done),
    .lighter_en   (lighter_en),
    .delay_num    (delay_num),
    .react_time   (react_time),
    .result_valid (result_valid),
    .false_start  (false_start),
    .timeout      (timeout),
    .busy         (busy),
    .best_time    (best_time)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] best_exp(input int v);
    return BEST_EN ? v : 1023;
  endfunction

  task automatic tick_n(input int n);
    repeat (n) begin
      tick_ms = 1'b1;
      step();
      tick_ms = 1'b0;
      step();
    end
  endtask

  // Start edge is registered, so the FSM acts on the second edge; ends in ARM.
  task automatic start_round(input logic [7:0] r);
    rand_num  = r;
    start_btn = 1'b1;
    step();
    step();
    start_btn = 1'b0;
  endtask

  // From ARM: lighter model raises done after dly cycles of enable; ends in TIMING.
  task automatic arm_to_timing(input int dly);
    step();
    repeat (dly - 1) step();
    lighter_done = 1'b1;
    step();
  endtask

  task automatic press_react();
    react_btn = 1'b1;
    step();
    step();
  endtask

  task automatic release_all();
    react_btn    = 1'b0;
    lighter_done = 1'b0;
    step();
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_lighter_en", lighter_en, 0);
    check("rst_delay_num", delay_num, 0);
    check("rst_react_time", react_time, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_false_start", false_start, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_best_time", best_time, 1023);

    // Round of 200 ms
    start_round(8'd50);
    check("r200_delay_num", delay_num, 50);
    check("r200_busy_arm", busy, 1);
    check("r200_en_arm", lighter_en, 0);
    arm_to_timing(10);
    check("r200_en_timing", lighter_en, 1);
    tick_n(200);
    press_react();
    check("r200_valid", result_valid, 1);
    check("r200_time", react_time, 200);
    check("r200_fs", false_start, 0);
    check("r200_to", timeout, 0);
    check("r200_en_done", lighter_en, 0);
    check("r200_busy_done", busy, 0);
    check("r200_best", best_time, best_exp(200));
    release_all();
    check("r200_valid_once", result_valid, 0);

    // Round of 150 ms with a start press mid-timing that must be ignored
    start_round(8'd40);
    arm_to_timing(40);
    tick_n(100);
    start_btn = 1'b1;
    step();
    step();
    check("ign_busy", busy, 1);
    check("ign_en", lighter_en, 1);
    start_btn = 1'b0;
    step();
    tick_n(50);
    press_react();
    check("r150_time", react_time, 150);
    check("r150_best", best_time, best_exp(150));
    release_all();

    // Clamped delay and false start
    start_round(8'd3);
    check("clamp_delay", delay_num, 16);
    step();
    step();
    step();
    check("fs_wait_en", lighter_en, 1);
    press_react();
    check("fs_flag", false_start, 1);
    check("fs_time", react_time, 0);
    check("fs_en", lighter_en, 0);
    check("fs_valid", result_valid, 1);
    check("fs_busy", busy, 0);
    check("fs_best", best_time, best_exp(150));
    release_all();
    check("fs_valid_once", result_valid, 0);

    // Round of 180 ms, restarted from FAULT
    start_round(8'd200);
    check("r180_delay", delay_num, 200);
    check("r180_fs_cleared", false_start, 0);
    arm_to_timing(5);
    tick_n(180);
    press_react();
    check("r180_time", react_time, 180);
    check("r180_best", best_time, best_exp(150));
    release_all();

    // Normal round of 123 ms, then a react press in DONE is ignored
    start_round(8'd40);
    check("r123_delay", delay_num, 40);
    arm_to_timing(40);
    tick_n(123);
    press_react();
    check("r123_time", react_time, 123);
    check("r123_valid", result_valid, 1);
    check("r123_en", lighter_en, 0);
    check("r123_best", best_time, best_exp(123));
    release_all();
    check("r123_valid_once", result_valid, 0);
    press_react();
    check("done_react_valid", result_valid, 0);
    check("done_react_time", react_time, 123);
    release_all();

    // Timeout after 999 ticks
    start_round(8'd20);
    arm_to_timing(20);
    tick_n(998);
    check("to_busy_998", busy, 1);
    check("to_valid_998", result_valid, 0);
    tick_ms = 1'b1;
    step();
    tick_ms = 1'b0;
    check("to_flag", timeout, 1);
    check("to_time", react_time, 1023);
    check("to_valid", result_valid, 1);
    check("to_fs", false_start, 0);
    check("to_en", lighter_en, 0);
    check("to_best", best_time, best_exp(123));
    step();
    check("to_valid_once", result_valid, 0);
    release_all();

    // react_rise together with lighter_done is a false start
    start_round(8'd60);
    check("sim_to_cleared", timeout, 0);
    step();
    react_btn = 1'b1;
    step();
    lighter_done = 1'b1;
    step();
    check("sim_light_fs", false_start, 1);
    check("sim_light_valid", result_valid, 1);
    check("sim_light_busy", busy, 0);
    release_all();

    // react_rise together with the 999th tick wins over the timeout
    start_round(8'd60);
    arm_to_timing(3);
    tick_n(998);
    react_btn = 1'b1;
    step();
    tick_ms = 1'b1;
    step();
    tick_ms = 1'b0;
    check("sim_tick_time", react_time, 998);
    check("sim_tick_to", timeout, 0);
    check("sim_tick_fs", false_start, 0);
    check("sim_tick_valid", result_valid, 1);
    release_all();

    // Reset mid-TIMING with start held through reset
    start_round(8'd30);
    arm_to_timing(3);
    tick_n(10);
    rst       = 1'b1;
    start_btn = 1'b1;
    step();
    check("mid_rst_en", lighter_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_delay", delay_num, 0);
    check("mid_rst_time", react_time, 0);
    check("mid_rst_fs", false_start, 0);
    check("mid_rst_to", timeout, 0);
    check("mid_rst_best", best_time, 1023);
    rst = 1'b0;
    step();
    step();
    check("post_rst_no_edge", busy, 0);
    start_btn = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
